// File: rtl/cmult_pkg.sv
// Shared defaults for the arbitrated complex multiplier: operand widths,
// requester count and the response-id width helper.
package cmult_pkg;

    localparam int DEF_COMPLEX_BIT = 24;
    localparam int DEF_FP_BIT      = 22;
    localparam int DEF_NUM_REQ     = 4;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmult_core.sv
// Four signed multipliers feeding the second pipeline stage, which holds the
// full-width real/imaginary sums (one guard bit above the 2*complex_bit product).
module cmult_core
    import cmult_pkg::*;
#(
    parameter int complex_bit = DEF_COMPLEX_BIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [complex_bit-1:0]   r1,
    input  logic [complex_bit-1:0]   i1,
    input  logic [complex_bit-1:0]   r2,
    input  logic [complex_bit-1:0]   i2,
    output logic [2*complex_bit:0]   prod_r,
    output logic [2*complex_bit:0]   prod_i
);

    localparam int PW = 2 * complex_bit;

    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    logic signed [PW-1:0] ri;
    logic signed [PW-1:0] ir;
    logic        [PW:0]   sum_r_next;
    logic        [PW:0]   sum_i_next;
    logic        [PW:0]   prod_r_reg;
    logic        [PW:0]   prod_i_reg;

    assign rr = $signed(r1) * $signed(r2);
    assign ii = $signed(i1) * $signed(i2);
    assign ri = $signed(r1) * $signed(i2);
    assign ir = $signed(i1) * $signed(r2);

    // Sign-extend by one bit so the add/subtract can never wrap.
    assign sum_r_next = {rr[PW-1], rr} - {ii[PW-1], ii};
    assign sum_i_next = {ri[PW-1], ri} + {ir[PW-1], ir};

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r_reg <= '0;
            prod_i_reg <= '0;
        end else if (en) begin
            prod_r_reg <= sum_r_next;
            prod_i_reg <= sum_i_next;
        end
    end

    assign prod_r = prod_r_reg;
    assign prod_i = prod_i_reg;

endmodule

// File: rtl/cmult_arbiter.sv
// Round-robin arbitrated two-stage complex multiplier with result backpressure.
// Define CMULT_ARBITER_SAT_EN to saturate instead of wrap on output overflow.
module cmult_arbiter
    import cmult_pkg::*;
#(
    parameter int complex_bit = DEF_COMPLEX_BIT,
    parameter int fp_bit      = DEF_FP_BIT,
    parameter int NUM_REQ     = DEF_NUM_REQ
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*complex_bit-1:0]   req_r1,
    input  logic [NUM_REQ*complex_bit-1:0]   req_i1,
    input  logic [NUM_REQ*complex_bit-1:0]   req_r2,
    input  logic [NUM_REQ*complex_bit-1:0]   req_i2,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [id_width(NUM_REQ)-1:0]     resp_id,
    output logic [complex_bit-1:0]           resp_r,
    output logic [complex_bit-1:0]           resp_i,
    output logic                             busy
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int PW  = 2 * complex_bit + 1;
    localparam int MSB = fp_bit + complex_bit - 1;

    logic [complex_bit-1:0] op_r1 [NUM_REQ];
    logic [complex_bit-1:0] op_i1 [NUM_REQ];
    logic [complex_bit-1:0] op_r2 [NUM_REQ];
    logic [complex_bit-1:0] op_i2 [NUM_REQ];

    logic [IDW-1:0]         ptr_reg;
    logic [IDW-1:0]         ptr_next;
    logic                   s1_valid_reg;
    logic [IDW-1:0]         s1_id_reg;
    logic [complex_bit-1:0] s1_r1_reg;
    logic [complex_bit-1:0] s1_i1_reg;
    logic [complex_bit-1:0] s1_r2_reg;
    logic [complex_bit-1:0] s1_i2_reg;
    logic                   s2_valid_reg;
    logic [IDW-1:0]         s2_id_reg;

    logic                   win_found;
    logic [IDW-1:0]         win_id;
    logic [IDW-1:0]         cand;
    int                     cand_sum;
    logic                   s2_free;
    logic                   s1_free;
    logic                   s1_to_s2;
    logic                   hs;

    logic [PW-1:0]          prod_r;
    logic [PW-1:0]          prod_i;
    logic [PW-1:0]          prod [2];
    logic [complex_bit-1:0] part [2];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_r1[gi] = req_r1[gi*complex_bit +: complex_bit];
        assign op_i1[gi] = req_i1[gi*complex_bit +: complex_bit];
        assign op_r2[gi] = req_r2[gi*complex_bit +: complex_bit];
        assign op_i2[gi] = req_i2[gi*complex_bit +: complex_bit];
    end

    // Scan requesters starting at the pointer; the first valid one wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        cand_sum  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_sum = int'(ptr_reg) + off;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand = IDW'(cand_sum);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign ptr_next = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    assign s2_free  = !s2_valid_reg || resp_ready;
    assign s1_free  = !s1_valid_reg || s2_free;
    assign s1_to_s2 = s1_valid_reg && s2_free;
    assign hs       = !rst && win_found && s1_free;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = hs && (win_id == IDW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            s1_r1_reg    <= '0;
            s1_i1_reg    <= '0;
            s1_r2_reg    <= '0;
            s1_i2_reg    <= '0;
            s2_valid_reg <= 1'b0;
            s2_id_reg    <= '0;
        end else begin
            if (hs) begin
                ptr_reg   <= ptr_next;
                s1_id_reg <= win_id;
                s1_r1_reg <= op_r1[win_id];
                s1_i1_reg <= op_i1[win_id];
                s1_r2_reg <= op_r2[win_id];
                s1_i2_reg <= op_i2[win_id];
            end
            s1_valid_reg <= hs || (s1_valid_reg && !s1_to_s2);
            if (s1_to_s2) begin
                s2_id_reg <= s1_id_reg;
            end
            s2_valid_reg <= s1_to_s2 || (s2_valid_reg && !resp_ready);
        end
    end

    cmult_core #(
        .complex_bit (complex_bit)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (s1_to_s2),
        .r1     (s1_r1_reg),
        .i1     (s1_i1_reg),
        .r2     (s1_r2_reg),
        .i2     (s1_i2_reg),
        .prod_r (prod_r),
        .prod_i (prod_i)
    );

    assign prod[0] = prod_r;
    assign prod[1] = prod_i;

    // Drop the fractional guard bits; the kept window is [MSB:fp_bit].
    for (genvar gi = 0; gi < 2; gi++) begin : g_scale
`ifdef CMULT_ARBITER_SAT_EN
        localparam logic [complex_bit-1:0] SAT_MAX = {1'b0, {(complex_bit-1){1'b1}}};
        localparam logic [complex_bit-1:0] SAT_MIN = {1'b1, {(complex_bit-1){1'b0}}};
        logic ovf;
        // Overflow when the bits above the window are not a copy of its sign.
        assign ovf = (|prod[gi][PW-1:MSB]) && !(&prod[gi][PW-1:MSB]);
        assign part[gi] = ovf ? (prod[gi][PW-1] ? SAT_MIN : SAT_MAX)
                              : prod[gi][MSB:fp_bit];
`else
        assign part[gi] = prod[gi][MSB:fp_bit];
`endif
    end

    logic unused_bits;
    assign unused_bits = ^{prod_r, prod_i};

    assign resp_valid = s2_valid_reg;
    assign resp_id    = s2_id_reg;
    assign resp_r     = part[0];
    assign resp_i     = part[1];
    assign busy       = s1_valid_reg || s2_valid_reg;

endmodule

// File: tb/tb_cmult_arbiter.sv
// Self-checking bench for cmult_arbiter: directed scenarios plus random traffic
// scored against an in-order queue model of round-robin grants and Q-format products.
`timescale 1ns/1ps
module tb_cmult_arbiter;
    import cmult_pkg::*;

    localparam int CB  = 24;
    localparam int FP  = 22;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*CB-1:0]   req_r1 = '0;
    logic [N*CB-1:0]   req_i1 = '0;
    logic [N*CB-1:0]   req_r2 = '0;
    logic [N*CB-1:0]   req_i2 = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [IDW-1:0]    resp_id;
    logic [CB-1:0]     resp_r;
    logic [CB-1:0]     resp_i;
    logic              busy;

    always #5 clk = ~clk;

    cmult_arbiter #(
        .complex_bit (CB),
        .fp_bit      (FP),
        .NUM_REQ     (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_r1     (req_r1),
        .req_i1     (req_i1),
        .req_r2     (req_r2),
        .req_i2     (req_i2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_r     (resp_r),
        .resp_i     (resp_i),
        .busy       (busy)
    );

    typedef struct {
        int          id;
        logic [CB-1:0] r;
        logic [CB-1:0] i;
        int          t;
    } item_t;

    item_t         q[$];
    int            dut_grants[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_pop = -10;
    int            ptr = 0;
    int            n_resp = 0;
    int            pend [N];
    logic [CB-1:0] op_r1 [N];
    logic [CB-1:0] op_i1 [N];
    logic [CB-1:0] op_r2 [N];
    logic [CB-1:0] op_i2 [N];
    bit            checking = 1'b0;
    logic          obs_valid;
    logic          obs_busy;
    logic [IDW-1:0] obs_id;
    logic [CB-1:0] obs_r;
    logic [CB-1:0] obs_i;
    logic [CB-1:0] last_r;
    logic [CB-1:0] last_i;

    // Exact product scaled to Q-format: floor(full / 2^FP), then wrap or clamp.
    function automatic logic [CB-1:0] fix(input longint full);
        longint        s;
        longint        lim;
        logic [CB-1:0] w;
        s   = full >>> FP;
        lim = longint'(1) << (CB - 1);
`ifdef CMULT_ARBITER_SAT_EN
        if (s >= lim) return {1'b0, {(CB-1){1'b1}}};
        if (s < -lim) return {1'b1, {(CB-1){1'b0}}};
`endif
        w = s[CB-1:0];
        return w;
    endfunction

    function automatic item_t model(input int id, input logic [CB-1:0] r1, input logic [CB-1:0] i1,
                                    input logic [CB-1:0] r2, input logic [CB-1:0] i2, input int t);
        item_t  it;
        longint ar;
        longint ai;
        longint br;
        longint bi;
        ar = longint'($signed(r1));
        ai = longint'($signed(i1));
        br = longint'($signed(r2));
        bi = longint'($signed(i2));
        it.id = id;
        it.r  = fix(ar * br - ai * bi);
        it.i  = fix(ar * bi + ai * br);
        it.t  = t;
        return it;
    endfunction

    function automatic logic [CB-1:0] rand_val();
        logic [CB-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 24'h7FFFFF;
            1:       v = 24'h800000;
            default: v = CB'($urandom);
        endcase
        return v;
    endfunction

    task automatic new_op(input int k);
        op_r1[k] = rand_val();
        op_i1[k] = rand_val();
        op_r2[k] = rand_val();
        op_i2[k] = rand_val();
    endtask

    // One clock: drive, check at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        int           win;
        int           idx;
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = (pend[k] > 0);
            req_r1[k*CB +: CB]    = op_r1[k];
            req_i1[k*CB +: CB]    = op_i1[k];
            req_r2[k*CB +: CB]    = op_r2[k];
            req_i2[k*CB +: CB]    = op_i2[k];
        end
        @(negedge clk);
        win = -1;
        if (!rst && (q.size() < 2 || resp_ready)) begin
            for (int off = 0; off < N; off++) begin
                idx = (ptr + off) % N;
                if (win < 0 && pend[idx] > 0) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_valid = (q.size() > 0) && (cyc >= q[0].t + 2) && (cyc >= last_pop + 1);
        if (checking) begin
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
            end
            checks++;
            if (resp_valid !== exp_valid) begin
                errors++;
                $display("FAIL resp_valid cyc=%0d: got %b expected %b", cyc, resp_valid, exp_valid);
            end
            checks++;
            if (busy !== (q.size() > 0)) begin
                errors++;
                $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, q.size() > 0);
            end
            if (exp_valid) begin
                checks++;
                if (resp_id !== IDW'(q[0].id) || resp_r !== q[0].r || resp_i !== q[0].i) begin
                    errors++;
                    $display("FAIL resp_data cyc=%0d: got id=%0d r=%h i=%h expected id=%0d r=%h i=%h",
                             cyc, resp_id, resp_r, resp_i, q[0].id, q[0].r, q[0].i);
                end
            end
        end
        obs_valid = resp_valid;
        obs_busy  = busy;
        obs_id    = resp_id;
        obs_r     = resp_r;
        obs_i     = resp_i;
        for (int k = 0; k < N; k++) begin
            if (req_ready[k] === 1'b1) dut_grants.push_back(k);
        end
        if (resp_valid === 1'b1 && resp_ready) begin
            n_resp++;
            last_r = resp_r;
            last_i = resp_i;
        end
        if (exp_valid && resp_ready) begin
            void'(q.pop_front());
            last_pop = cyc;
        end
        if (win >= 0) begin
            q.push_back(model(win, op_r1[win], op_i1[win], op_r2[win], op_i2[win], cyc));
            ptr = (win + 1) % N;
            pend[win]--;
            new_op(win);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            ptr      = 0;
            last_pop = -10;
        end
    endtask

    task automatic drain();
        int budget;
        bit pending;
        resp_ready = 1'b1;
        budget = 0;
        pending = 1'b1;
        while (pending && budget < 200) begin
            cycle();
            budget++;
            pending = (q.size() > 0);
            for (int k = 0; k < N; k++) if (pend[k] > 0) pending = 1'b1;
        end
        checks++;
        if (pending) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            pend[k] = 1;
            new_op(k);
        end
        rst = 1'b1;
        checking = 1'b0;
        cycle();
        checking = 1'b1;
        cycle();
        for (int k = 0; k < N; k++) pend[k] = 0;
        rst = 1'b0;
        cycle();
        checks++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_id !== '0 || obs_r !== '0 || obs_i !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b busy=%b id=%0d r=%h i=%h expected all zero",
                     obs_valid, obs_busy, obs_id, obs_r, obs_i);
        end
    endtask

    task automatic test_single();
        op_r1[1] = 24'h400000;
        op_i1[1] = 24'h000000;
        op_r2[1] = 24'h000000;
        op_i2[1] = 24'h400000;
        pend[1]  = 1;
        cycle();
        cycle();
        cycle();
        checks++;
        if (obs_valid !== 1'b1 || obs_id !== 2'd1 || obs_r !== 24'h000000 || obs_i !== 24'h400000) begin
            errors++;
            $display("FAIL single_op: got valid=%b id=%0d r=%h i=%h expected valid=1 id=1 r=000000 i=400000",
                     obs_valid, obs_id, obs_r, obs_i);
        end
        drain();
    endtask

    task automatic test_contention();
        int g0;
        int nv;
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < N; k++) pend[k] = 2;
        g0 = dut_grants.size();
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c >= 2 && obs_valid === 1'b1) nv++;
        end
        checks++;
        if (dut_grants.size() - g0 != 8) begin
            errors++;
            $display("FAIL contention_grants: got %0d expected 8", dut_grants.size() - g0);
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (dut_grants[g0 + j] != order[j]) begin
                    errors++;
                    $display("FAIL contention_order[%0d]: got %0d expected %0d", j, dut_grants[g0 + j], order[j]);
                end
            end
        end
        checks++;
        if (nv != 8) begin
            errors++;
            $display("FAIL contention_throughput: got %0d responses expected 8", nv);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int g0;
        int r0;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1;
            new_op(k);
        end
        g0 = dut_grants.size();
        r0 = n_resp;
        for (int c = 0; c < 5; c++) cycle();
        checks++;
        if (dut_grants.size() - g0 != 2) begin
            errors++;
            $display("FAIL backpressure_accepted: got %0d expected 2", dut_grants.size() - g0);
        end
        drain();
        checks++;
        if (n_resp - r0 != 3) begin
            errors++;
            $display("FAIL backpressure_responses: got %0d expected 3", n_resp - r0);
        end
    endtask

    task automatic test_overflow();
        logic [CB-1:0] exp_r;
`ifdef CMULT_ARBITER_SAT_EN
        exp_r = 24'h7FFFFF;
`else
        exp_r = 24'hFFFFFC;
`endif
        op_r1[0] = 24'h7FFFFF;
        op_i1[0] = 24'h000000;
        op_r2[0] = 24'h7FFFFF;
        op_i2[0] = 24'h000000;
        pend[0]  = 1;
        drain();
        checks++;
        if (last_r !== exp_r || last_i !== 24'h000000) begin
            errors++;
            $display("FAIL overflow: got r=%h i=%h expected r=%h i=000000", last_r, last_i, exp_r);
        end
    endtask

    task automatic test_reset_midflight();
        pend[2] = 1;
        new_op(2);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
                errors++;
                $display("FAIL midflight_flush: got valid=%b busy=%b expected 0 0", obs_valid, obs_busy);
            end
        end
        for (int k = 0; k < N; k++) pend[k] = 1;
        cycle();
        checks++;
        if (dut_grants.size() == 0 || dut_grants[dut_grants.size() - 1] != 0) begin
            errors++;
            $display("FAIL midflight_next_grant: got %0d expected 0",
                     (dut_grants.size() == 0) ? -1 : dut_grants[dut_grants.size() - 1]);
        end
        drain();
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 5) begin
                k = $urandom_range(0, N - 1);
                if (pend[k] < 3) pend[k]++;
            end
            resp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 0;
            new_op(k);
        end
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overflow();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
